// File: rtl/hex_scroll_controller.sv
// Scrolling hex marquee: FIFO-buffered digits shift right-to-left across HEX5..HEX0.
// Define HEX_DP_MARK_EN to carry a per-digit decimal point through the FIFO and displays.
module hex_scroll_controller #(
  parameter int TICK_DIV   = 12500000,
  parameter int FIFO_DEPTH = 8,
  parameter int HOLD_TICKS = 8
) (
  input  logic                          CLOCK_50,
  input  logic                          RESET_N,
  input  logic                          enable,
  input  logic                          in_valid,
  input  logic [3:0]                    in_digit,
  input  logic                          in_blank,
  input  logic                          in_dp,
  output logic                          in_ready,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [7:0]                    HEX0,
  output logic [7:0]                    HEX1,
  output logic [7:0]                    HEX2,
  output logic [7:0]                    HEX3,
  output logic [7:0]                    HEX4,
  output logic [7:0]                    HEX5
);

  // state    | meaning
  // ST_IDLE  | display blank, waiting for the first digit
  // ST_RUN   | popping one digit per tick
  // ST_HOLD  | FIFO ran dry, display frozen for HOLD_TICKS ticks
  // ST_DRAIN | shifting blanks in until all six displays are clear

  localparam int CNT_W  = $clog2(TICK_DIV);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

`ifdef HEX_DP_MARK_EN
  localparam int ENT_W = 6;
`else
  localparam int ENT_W = 5;
`endif

  localparam logic [CNT_W-1:0]  TC_LAST   = CNT_W'(TICK_DIV - 1);
  localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HOLD, ST_DRAIN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [2:0]         drain_q, drain_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic [ENT_W-1:0]   mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0]   mem_d [FIFO_DEPTH];
  logic [7:0]         hex_q [6];
  logic [7:0]         hex_d [6];

  logic               tick, pop, push, shift_blank, fifo_empty;
  logic [ENT_W-1:0]   wr_entry;

`ifdef HEX_DP_MARK_EN
  assign wr_entry = {in_dp, in_blank, in_digit};
`else
  logic unused_dp;
  assign unused_dp = in_dp;
  assign wr_entry  = {in_blank, in_digit};
`endif

  // Entry layout: [3:0] digit, [4] blank, [5] dp (when carried).
  function automatic logic [7:0] glyph(input logic [ENT_W-1:0] e);
    logic [7:0] g;
    case (e[3:0])
      4'h0: g = 8'hC0;  4'h1: g = 8'hF9;  4'h2: g = 8'hA4;  4'h3: g = 8'hB0;
      4'h4: g = 8'h99;  4'h5: g = 8'h92;  4'h6: g = 8'h82;  4'h7: g = 8'hF8;
      4'h8: g = 8'h80;  4'h9: g = 8'h90;  4'hA: g = 8'h88;  4'hB: g = 8'h83;
      4'hC: g = 8'hC6;  4'hD: g = 8'hA1;  4'hE: g = 8'h86;  default: g = 8'h8E;
    endcase
    if (e[4]) g = 8'hFF;
`ifdef HEX_DP_MARK_EN
    else if (e[5]) g[7] = 1'b0;
`endif
    return g;
  endfunction

  assign fifo_empty = (count_q == '0);
  assign in_ready   = (count_q != FULL_CNT);
  assign push       = in_valid && in_ready;
  assign fifo_count = count_q;

  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
  assign HEX3 = hex_q[3];
  assign HEX4 = hex_q[4];
  assign HEX5 = hex_q[5];

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      hold_q     <= '0;
      drain_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      hex_q      <= '{default: 8'hFF};
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      hold_q     <= hold_d;
      drain_q    <= drain_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      hex_q      <= hex_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge CLOCK_50) begin
    mem_q <= mem_d;
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    drain_d = drain_q;
    case (state_q)
      ST_IDLE: begin
        hold_d  = '0;
        drain_d = '0;
        // A push landing on the final drain edge leaves data behind in IDLE.
        if (push || !fifo_empty) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (tick && fifo_empty) begin
          state_d = ST_HOLD;
          hold_d  = '0;
        end
      end
      ST_HOLD: begin
        if (tick) begin
          if (!fifo_empty) begin
            state_d = ST_RUN;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
            if (hold_q == HOLD_LAST) begin
              state_d = ST_DRAIN;
              drain_d = '0;
            end
          end
        end
      end
      default: begin
        if (tick) begin
          if (!fifo_empty) begin
            state_d = ST_RUN;
          end else begin
            drain_d = drain_q + 3'd1;
            if (drain_q == 3'd5) begin
              state_d = ST_IDLE;
              drain_d = '0;
            end
          end
        end
      end
    endcase
  end

  always_comb begin
    busy        = (state_q != ST_IDLE);
    tick        = busy && enable && (tick_cnt_q == TC_LAST);
    pop         = tick && !fifo_empty;
    shift_blank = tick && fifo_empty && (state_q == ST_DRAIN);
  end

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (!busy || tick) tick_cnt_d = '0;
    else if (enable)   tick_cnt_d = tick_cnt_q + CNT_W'(1);

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = wr_entry;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase

    hex_d = hex_q;
    if (pop || shift_blank) begin
      for (int i = 5; i > 0; i--) hex_d[i] = hex_q[i-1];
      hex_d[0] = pop ? glyph(mem_q[rd_ptr_q]) : 8'hFF;
    end
  end

endmodule
